// File: rtl/multi_port_ram_write_buffer_pkg.sv
// rtl/multi_port_ram_write_buffer_pkg.sv - shared types and sizing for the RAM write buffer
package multi_port_ram_write_buffer_pkg;

  localparam int ENTRY_NUM      = 4;
  localparam int INDEX_BIT_SIZE = $clog2(ENTRY_NUM);
  localparam int ENTRY_BIT_SIZE = 4;
  localparam int IN_NUM         = 2;
  localparam int WRITE_NUM      = 2;
  localparam int READ_NUM       = 2;
  localparam int DEPTH          = 8;
  localparam int PTR_BIT_SIZE   = $clog2(DEPTH);
  localparam int COUNT_BIT_SIZE = $clog2(DEPTH + 1);

  typedef logic [INDEX_BIT_SIZE-1:0] RamIndexPath;
  typedef logic [ENTRY_BIT_SIZE-1:0] RamDataPath;
  typedef logic [PTR_BIT_SIZE-1:0]   WriteBufferPtrPath;
  typedef logic [COUNT_BIT_SIZE-1:0] WriteBufferCountPath;

  typedef struct packed {
    RamIndexPath addr;
    RamDataPath  data;
  } WriteBufferEntry;

  // DEPTH is a power of two, so truncating to the pointer width is the wrap.
  function automatic WriteBufferPtrPath wrap_ptr(WriteBufferPtrPath base, int offset);
    return base + WriteBufferPtrPath'(offset);
  endfunction

endpackage

// File: rtl/multi_port_ram_write_buffer_if.sv
// rtl/multi_port_ram_write_buffer_if.sv - request, RAM write and pending-read signals of the write buffer
interface multi_port_ram_write_buffer_if;
  import multi_port_ram_write_buffer_pkg::*;

  logic        [IN_NUM-1:0]    inValid;
  RamIndexPath [IN_NUM-1:0]    inAddr;
  RamDataPath  [IN_NUM-1:0]    inData;
  logic                        inReady;
  logic        [WRITE_NUM-1:0] we;
  RamIndexPath [WRITE_NUM-1:0] wa;
  RamDataPath  [WRITE_NUM-1:0] wv;
  RamIndexPath [READ_NUM-1:0]  ra;
  logic        [READ_NUM-1:0]  pendingHit;

  modport master (
    output inValid, inAddr, inData, ra,
    input  inReady, we, wa, wv, pendingHit
  );

  modport slave (
    input  inValid, inAddr, inData, ra,
    output inReady, we, wa, wv, pendingHit
  );

endinterface

// File: rtl/multi_port_ram_write_drain_select.sv
// rtl/multi_port_ram_write_drain_select.sv - picks the in-order conflict-free drain group at the buffer head
module multi_port_ram_write_drain_select
  import multi_port_ram_write_buffer_pkg::*;
(
  input  WriteBufferEntry     [WRITE_NUM-1:0] head_entry,
  input  WriteBufferCountPath                 count,
  output logic                [WRITE_NUM-1:0] sel
);

  // Grow the group from the head; stop at the first empty slot or repeated address.
  always_comb begin
    logic keep;
    sel  = '0;
    keep = 1'b1;
    for (int k = 0; k < WRITE_NUM; k++) begin
      if (WriteBufferCountPath'(k) >= count) keep = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (head_entry[j].addr == head_entry[k].addr) keep = 1'b0;
      end
      sel[k] = keep;
    end
  end

endmodule

// File: rtl/multi_port_ram_write_buffer.sv
// rtl/multi_port_ram_write_buffer.sv - in-order circular write buffer feeding a multi-port RAM
module multi_port_ram_write_buffer
  import multi_port_ram_write_buffer_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  multi_port_ram_write_buffer_if.slave   bus,
  output WriteBufferCountPath            count,
  output logic                           empty,
  output logic                           full
);

  WriteBufferEntry     slot_q [DEPTH];
  WriteBufferPtrPath   head_q;
  WriteBufferPtrPath   tail_q;
  WriteBufferCountPath count_q;

  WriteBufferEntry   [WRITE_NUM-1:0] head_entry;
  logic              [WRITE_NUM-1:0] drain_sel;
  WriteBufferCountPath               pop_num;
  WriteBufferCountPath               push_num;
  logic                              space_ok;
  logic                              enq_en;
  logic              [IN_NUM-1:0]    lane_wr;
  WriteBufferPtrPath [IN_NUM-1:0]    lane_slot;

  // Room is judged on the registered count only; same-cycle pops do not help.
  assign space_ok    = count_q <= WriteBufferCountPath'(DEPTH - IN_NUM);
  assign enq_en      = space_ok && !rst;
  assign bus.inReady = space_ok || rst;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == WriteBufferCountPath'(DEPTH));

  // Gather the oldest WRITE_NUM entries as drain candidates.
  always_comb begin
    head_entry = '0;
    for (int k = 0; k < WRITE_NUM; k++) begin
      head_entry[k] = slot_q[wrap_ptr(head_q, k)];
    end
  end

  multi_port_ram_write_drain_select u_drain_select (
    .head_entry (head_entry),
    .count      (count_q),
    .sel        (drain_sel)
  );

  // Drive the RAM write ports; unused ports carry zeros and nothing is written during reset.
  always_comb begin
    bus.we  = '0;
    bus.wa  = '0;
    bus.wv  = '0;
    pop_num = '0;
    for (int k = 0; k < WRITE_NUM; k++) begin
      if (drain_sel[k] && !rst) begin
        bus.we[k] = 1'b1;
        bus.wa[k] = head_entry[k].addr;
        bus.wv[k] = head_entry[k].data;
        pop_num   = pop_num + WriteBufferCountPath'(1);
      end
    end
  end

  // Compact valid lanes in lane order onto consecutive slots from the tail.
  always_comb begin
    push_num  = '0;
    lane_wr   = '0;
    lane_slot = '0;
    for (int i = 0; i < IN_NUM; i++) begin
      if (enq_en && bus.inValid[i]) begin
        lane_wr[i]   = 1'b1;
        lane_slot[i] = wrap_ptr(tail_q, int'(push_num));
        push_num     = push_num + WriteBufferCountPath'(1);
      end
    end
  end

  // Flag read addresses that still have a buffered update, including entries popping now.
  always_comb begin
    WriteBufferPtrPath offset;
    bus.pendingHit = '0;
    offset         = '0;
    for (int r = 0; r < READ_NUM; r++) begin
      for (int d = 0; d < DEPTH; d++) begin
        offset = WriteBufferPtrPath'(d) - head_q;
        if (!rst && (WriteBufferCountPath'(offset) < count_q) && (slot_q[d].addr == bus.ra[r])) begin
          bus.pendingHit[r] = 1'b1;
        end
      end
    end
  end

  // Pointer and occupancy bookkeeping; reset drops everything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + WriteBufferPtrPath'(pop_num);
      tail_q  <= tail_q + WriteBufferPtrPath'(push_num);
      count_q <= count_q + push_num - pop_num;
    end
  end

  // Entry storage; only accepted lanes are written, so no reset is needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_NUM; i++) begin
      if (lane_wr[i]) slot_q[lane_slot[i]] <= '{addr: bus.inAddr[i], data: bus.inData[i]};
    end
  end

endmodule

// File: tb/tb_multi_port_ram_write_buffer.sv
// tb/tb_multi_port_ram_write_buffer.sv - directed scoreboard bench for the RAM write buffer
module tb_multi_port_ram_write_buffer;
  import multi_port_ram_write_buffer_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  WriteBufferCountPath count;
  logic                empty;
  logic                full;

  multi_port_ram_write_buffer_if bus ();

  multi_port_ram_write_buffer dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always #5 clk = ~clk;

  int              errors = 0;
  int              checks = 0;
  WriteBufferEntry sb[$];
  RamDataPath      ram_model [ENTRY_NUM];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic [1:0] v, RamIndexPath a0, RamDataPath d0, RamIndexPath a1, RamDataPath d1);
    bus.inValid   = v;
    bus.inAddr[0] = a0;
    bus.inData[0] = d0;
    bus.inAddr[1] = a1;
    bus.inData[1] = d1;
    #1;
  endtask

  task automatic idle();
    drive(2'b00, 0, 0, 0, 0);
  endtask

  // Score this cycle's RAM writes, record accepted requests, then advance one clock.
  task automatic tick();
    WriteBufferEntry e;
    if (!rst) begin
      for (int k = 0; k < WRITE_NUM; k++) begin
        if (bus.we[k]) begin
          check("sb_has_entry", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("drain_addr", bus.wa[k], e.addr);
            check("drain_data", bus.wv[k], e.data);
          end
          ram_model[bus.wa[k]] = bus.wv[k];
        end
      end
      if (bus.we[0] && bus.we[1]) check("distinct_addr", bus.wa[0] != bus.wa[1], 1);
      if (bus.inReady) begin
        for (int i = 0; i < IN_NUM; i++) begin
          if (bus.inValid[i]) sb.push_back('{addr: bus.inAddr[i], data: bus.inData[i]});
        end
      end
    end
    @(posedge clk);
    if (rst) sb.delete();
    @(negedge clk);
  endtask

  initial begin
    int         exp_count;
    logic       rdy;
    RamDataPath d;

    for (int i = 0; i < ENTRY_NUM; i++) ram_model[i] = '0;
    bus.ra[0] = 0;
    bus.ra[1] = 0;

    // 1: reset
    rst = 1'b1;
    idle(); tick();
    idle(); tick();
    rst = 1'b0;
    idle();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ready", bus.inReady, 1);
    check("rst_we", bus.we, 2'b00);
    check("rst_pending", bus.pendingHit, 2'b00);
    tick();

    // 2: single write, exact one-cycle latency, no bypass
    drive(2'b01, 2, 4'hA, 0, 0);
    check("t2_no_bypass", bus.we, 2'b00);
    tick();
    idle();
    check("t2_we", bus.we, 2'b01);
    check("t2_wa0", bus.wa[0], 2);
    check("t2_wv0", bus.wv[0], 4'hA);
    tick();
    idle();
    check("t2_empty", empty, 1);
    tick();

    // 3: two distinct addresses drain together
    drive(2'b11, 1, 4'h3, 2, 4'h5);
    tick();
    idle();
    check("t3_we", bus.we, 2'b11);
    check("t3_wa0", bus.wa[0], 1);
    check("t3_wa1", bus.wa[1], 2);
    check("t3_wv0", bus.wv[0], 4'h3);
    check("t3_wv1", bus.wv[1], 4'h5);
    tick();
    idle();
    check("t3_count", count, 0);
    tick();

    // 4: same-address pair is split, younger write lands last
    drive(2'b11, 3, 4'h1, 3, 4'h7);
    tick();
    idle();
    check("t4_we_a", bus.we, 2'b01);
    check("t4_wv_a", bus.wv[0], 4'h1);
    tick();
    idle();
    check("t4_we_b", bus.we, 2'b01);
    check("t4_wa_b", bus.wa[0], 3);
    check("t4_wv_b", bus.wv[0], 4'h7);
    tick();
    idle();
    check("t4_ram3", ram_model[3], 4'h7);
    check("t4_count", count, 0);
    tick();

    // 5: saturate with same-address pairs; backpressure at count 7
    exp_count = 0;
    d = 4'h0;
    for (int i = 0; i < 12; i++) begin
      drive(2'b11, 0, d, 0, RamDataPath'(d + 4'h1));
      rdy = (exp_count <= DEPTH - IN_NUM);
      check("t5_count", count, exp_count);
      check("t5_ready", bus.inReady, rdy);
      tick();
      exp_count = exp_count + (rdy ? 2 : 0) - (exp_count > 0 ? 1 : 0);
      if (rdy) d = RamDataPath'(d + 4'h2);
    end
    for (int i = 0; i < 20 && !empty; i++) begin
      idle();
      tick();
    end
    idle();
    check("t5_drained", empty, 1);
    check("t5_sb_empty", sb.size() == 0, 1);
    tick();

    // 6: pending-hit lookup, then mid-operation reset
    bus.ra[0] = 1;
    bus.ra[1] = 3;
    drive(2'b01, 1, 4'h9, 0, 0);
    check("t6_hit_excl_enq", bus.pendingHit, 2'b00);
    tick();
    idle();
    check("t6_hit", bus.pendingHit, 2'b01);
    tick();
    idle();
    check("t6_hit_cleared", bus.pendingHit, 2'b00);
    tick();
    bus.ra[0] = 0;
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 0, RamDataPath'(2 * i), 0, RamDataPath'(2 * i + 1));
      tick();
    end
    idle();
    check("t6_count5", count, 5);
    check("t6_hit_addr0", bus.pendingHit, 2'b01);
    rst = 1'b1;
    idle();
    check("t6_rst_we", bus.we, 2'b00);
    tick();
    rst = 1'b0;
    idle();
    check("t6_post_count", count, 0);
    check("t6_post_we", bus.we, 2'b00);
    check("t6_post_hit", bus.pendingHit, 2'b00);
    check("t6_post_empty", empty, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      idle();
      check("t6_no_stale_we", bus.we, 2'b00);
    end
    check("t6_sb_empty", sb.size() == 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
